// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// The ID stage drives the master modport; the scoreboard consumes the slave modport.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            iss_valid;
  logic [AW-1:0]   iss_rs;
  logic [AW-1:0]   iss_rt;
  logic            iss_use_rs;
  logic            iss_use_rt;
  logic            iss_wr_en;
  logic [AW-1:0]   iss_wr;
  logic [CW-1:0]   iss_lat;
  logic            iss_is_load;
  logic            flush;
  logic            stall;
  logic            iss_fire;
  logic [NREG-1:0] busy_vec;
  logic [AW:0]     pend_cnt;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt,
           iss_wr_en, iss_wr, iss_lat, iss_is_load, flush,
    input  stall, iss_fire, busy_vec, pend_cnt
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt,
           iss_wr_en, iss_wr, iss_lat, iss_is_load, flush,
    output stall, iss_fire, busy_vec, pend_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing RAW/WAW stalls for the issue stage.
// Optional macro HAZARD_FWD_EN: ALU results are forwarded, only young loads block readers.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 4,
  parameter int CW      = 3,
  parameter int LD_FWD  = 2
) (
  input  logic              clk,
  input  logic              clrn,
  hazard_scoreboard_if.slave sb
);

  logic [CW-1:0]   r_cnt [NREG];
  logic [NREG-1:0] r_ld;

  logic [CW-1:0]   w_lat;
  logic            w_rs_haz;
  logic            w_rt_haz;
  logic            w_waw;
  logic            w_stall;
  logic            w_fire;
  logic            w_set;
  logic [NREG-1:0] w_busy;
  logic [AW:0]     w_pend;

  // A latency of zero still needs one cycle to write back, so it is treated as one.
  always_comb begin
    w_lat = sb.iss_lat;
    if (sb.iss_lat == '0) begin
      w_lat = CW'(1);
    end else if (sb.iss_lat > CW'(MAX_LAT)) begin
      w_lat = CW'(MAX_LAT);
    end
  end

`ifdef HAZARD_FWD_EN
  assign w_rs_haz = sb.iss_use_rs && (sb.iss_rs != '0) && r_ld[sb.iss_rs] &&
                    (r_cnt[sb.iss_rs] > CW'(LD_FWD));
  assign w_rt_haz = sb.iss_use_rt && (sb.iss_rt != '0) && r_ld[sb.iss_rt] &&
                    (r_cnt[sb.iss_rt] > CW'(LD_FWD));
`else
  logic w_unused;
  assign w_unused = ^{r_ld, CW'(LD_FWD)};
  assign w_rs_haz = sb.iss_use_rs && (sb.iss_rs != '0) && (r_cnt[sb.iss_rs] != '0);
  assign w_rt_haz = sb.iss_use_rt && (sb.iss_rt != '0) && (r_cnt[sb.iss_rt] != '0);
`endif

  // An older write finishing after this one would clobber the newer result.
  assign w_waw   = sb.iss_wr_en && (sb.iss_wr != '0) && (r_cnt[sb.iss_wr] > w_lat);
  assign w_stall = clrn && sb.iss_valid && (w_rs_haz || w_rt_haz || w_waw);
  assign w_fire  = clrn && sb.iss_valid && !w_stall && !sb.flush;
  assign w_set   = w_fire && sb.iss_wr_en && (sb.iss_wr != '0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_ld <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (sb.flush) begin
          r_cnt[i] <= '0;
          r_ld[i]  <= 1'b0;
        end else if (w_set && (sb.iss_wr == AW'(i))) begin
          r_cnt[i] <= w_lat;
          r_ld[i]  <= sb.iss_is_load;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
          if (r_cnt[i] == CW'(1)) begin
            r_ld[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_busy = '0;
    w_pend = '0;
    for (int i = 0; i < NREG; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
      w_pend    = w_pend + (AW + 1)'(w_busy[i]);
    end
  end

  assign sb.stall    = w_stall;
  assign sb.iss_fire = w_fire;
  assign sb.busy_vec = w_busy;
  assign sb.pend_cnt = w_pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, RAW, r0, override, clamp, WAW, flush,
// and the load-forwarding variant when HAZARD_FWD_EN is defined.
module tb_hazard_scoreboard;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic clrn;
  int   errors = 0;
  int   checks = 0;

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .CW(CW)) sbIf ();

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAX_LAT(4), .CW(CW), .LD_FWD(2)) dut (
    .clk  (clk),
    .clrn (clrn),
    .sb   (sbIf.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic useRs, input logic [AW-1:0] rs,
                               input logic useRt, input logic [AW-1:0] rt,
                               input logic wrEn, input logic [AW-1:0] wr,
                               input logic [CW-1:0] lat, input logic isLoad, input logic fl);
    sbIf.iss_valid   = valid;
    sbIf.iss_use_rs  = useRs;
    sbIf.iss_rs      = rs;
    sbIf.iss_use_rt  = useRt;
    sbIf.iss_rt      = rt;
    sbIf.iss_wr_en   = wrEn;
    sbIf.iss_wr      = wr;
    sbIf.iss_lat     = lat;
    sbIf.iss_is_load = isLoad;
    sbIf.flush       = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled well away from the rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit expired");
  end

  initial begin
    clrn = 1'b0;
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_stall", 32'(sbIf.stall), 32'd0);
    checkOutput("rst_fire", 32'(sbIf.iss_fire), 32'd0);
    checkOutput("rst_busy", sbIf.busy_vec, 32'h0);
    checkOutput("rst_pend", 32'(sbIf.pend_cnt), 32'd0);
    waitCycle();
    clrn = 1'b1;
    #1;
    checkOutput("rel_fire", 32'(sbIf.iss_fire), 32'd1);
    waitCycle();

    // RAW on r3 with latency 3
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 3, 0, 0);
    checkOutput("raw_iss_fire", 32'(sbIf.iss_fire), 32'd1);
    waitCycle();
    applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_novalid_stall", 32'(sbIf.stall), 32'd0);
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_c1_stall", 32'(sbIf.stall), 32'd1);
    checkOutput("raw_c1_fire", 32'(sbIf.iss_fire), 32'd0);
    checkOutput("raw_c1_busy", sbIf.busy_vec, 32'h8);
    checkOutput("raw_c1_pend", 32'(sbIf.pend_cnt), 32'd1);
    waitCycle();
    checkOutput("raw_c2_stall", 32'(sbIf.stall), 32'd1);
    waitCycle();
    checkOutput("raw_c3_stall", 32'(sbIf.stall), 32'd1);
    checkOutput("raw_c3_pend", 32'(sbIf.pend_cnt), 32'd1);
    waitCycle();
    checkOutput("raw_c4_stall", 32'(sbIf.stall), 32'd0);
    checkOutput("raw_c4_fire", 32'(sbIf.iss_fire), 32'd1);
    checkOutput("raw_c4_pend", 32'(sbIf.pend_cnt), 32'd0);

    // Writes to r0 are dropped and r0 sources never stall
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 4, 0, 0);
    checkOutput("r0_fire", 32'(sbIf.iss_fire), 32'd1);
    waitCycle();
    checkOutput("r0_busy", sbIf.busy_vec, 32'h0);
    checkOutput("r0_pend", 32'(sbIf.pend_cnt), 32'd0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_read_stall", 32'(sbIf.stall), 32'd0);

    // Reissue to r5 while its counter is 1: new value 4 wins
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    waitCycle();
    checkOutput("ovr_busy1", sbIf.busy_vec, 32'h20);
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 4, 0, 0);
    checkOutput("ovr_stall", 32'(sbIf.stall), 32'd0);
    checkOutput("ovr_fire", 32'(sbIf.iss_fire), 32'd1);
    waitCycle();
    idle();
    checkOutput("ovr_busy_after", sbIf.busy_vec, 32'h20);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("ovr_busy_cnt1", sbIf.busy_vec, 32'h20);
    waitCycle();
    checkOutput("ovr_busy_clear", sbIf.busy_vec, 32'h0);

    // Latency 0 behaves as latency 1
    applyStimulus(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    waitCycle();
    idle();
    checkOutput("lat0_busy", sbIf.busy_vec, 32'h40);
    waitCycle();
    checkOutput("lat0_clear", sbIf.busy_vec, 32'h0);

    // WAW: cnt[4]=3 blocks a latency-2 write until it drops to 2
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 3, 0, 0);
    waitCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 2, 0, 0);
    checkOutput("waw_stall", 32'(sbIf.stall), 32'd1);
    checkOutput("waw_fire", 32'(sbIf.iss_fire), 32'd0);
    waitCycle();
    checkOutput("waw_eq_stall", 32'(sbIf.stall), 32'd0);
    checkOutput("waw_eq_fire", 32'(sbIf.iss_fire), 32'd1);
    waitCycle();
    idle();
    checkOutput("waw_busy", sbIf.busy_vec, 32'h10);
    waitCycle();
    waitCycle();
    checkOutput("waw_clear", sbIf.busy_vec, 32'h0);

    // Latency 7 clamps to 4, so a latency-3 write to r9 must wait one cycle
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 7, 0, 0);
    waitCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 3, 0, 0);
    checkOutput("clamp_waw_stall", 32'(sbIf.stall), 32'd1);
    waitCycle();
    checkOutput("clamp_waw_fire", 32'(sbIf.iss_fire), 32'd1);
    waitCycle();
    applyStimulus(1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    checkOutput("rt_raw_stall", 32'(sbIf.stall), 32'd1);
    idle();
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("clamp_pend", 32'(sbIf.pend_cnt), 32'd0);

    // Flush kills three pending writes and the flush-cycle issue
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 4, 0, 0);
    waitCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 11, 4, 0, 0);
    waitCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 12, 4, 0, 0);
    waitCycle();
    idle();
    checkOutput("fl_pend3", 32'(sbIf.pend_cnt), 32'd3);
    checkOutput("fl_busy3", sbIf.busy_vec, 32'h1C00);
    applyStimulus(1, 1, 12, 0, 0, 1, 13, 4, 0, 1);
    checkOutput("fl_stall", 32'(sbIf.stall), 32'd1);
    checkOutput("fl_fire", 32'(sbIf.iss_fire), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 1, 13, 4, 0, 1);
    checkOutput("fl_fire_nohaz", 32'(sbIf.iss_fire), 32'd0);
    waitCycle();
    idle();
    checkOutput("fl_pend0", 32'(sbIf.pend_cnt), 32'd0);
    checkOutput("fl_busy0", sbIf.busy_vec, 32'h0);

`ifdef HAZARD_FWD_EN
    // Load r7 lat 4 blocks for two cycles; ALU r8 forwards immediately
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 4, 1, 0);
    waitCycle();
    applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fwd_ld_c1", 32'(sbIf.stall), 32'd1);
    waitCycle();
    checkOutput("fwd_ld_c2", 32'(sbIf.stall), 32'd1);
    waitCycle();
    checkOutput("fwd_ld_c3", 32'(sbIf.stall), 32'd0);
    checkOutput("fwd_ld_fire", 32'(sbIf.iss_fire), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 1, 8, 3, 0, 0);
    waitCycle();
    applyStimulus(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fwd_alu_stall", 32'(sbIf.stall), 32'd0);
    checkOutput("fwd_alu_fire", 32'(sbIf.iss_fire), 32'd1);
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
